arbiter_hold: RTL and testbench

//  Round-robin arbiter that grants a shared resource for a multi-cycle tenure.
//  The owner keeps the grant until it releases, drops its request or hits a

---
 rtl/arbiter_hold_pkg.sv | 15 +
 rtl/arbiter_hold_rr_pick.sv | 44 ++++
 rtl/arbiter_hold.sv | 127 ++++++++++++
 tb/tb_arbiter_hold.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_hold_pkg.sv
// Shared definitions for the hold-tenure round-robin arbiter.
// State encodings and width helpers used by the top level and the picker.
package arbiter_hold_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

  // Width of a binary index over n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arbiter_hold_rr_pick.sv
// Combinational round-robin picker: first eligible request at or above pointer, with wrap.
// The eligible vector is doubled and shifted so a plain find-first yields the offset.
module rr_pick
  import arbiter_hold_pkg::*;
#(
  parameter int NUM_PORTS = 6,
  parameter int IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] request,
  input  logic [NUM_PORTS-1:0] mask,
  input  logic [IDX_W-1:0]     pointer,
  output logic [NUM_PORTS-1:0] onehot,
  output logic [IDX_W-1:0]     index,
  output logic                 found
);

  logic [NUM_PORTS-1:0]   eligible;
  logic [2*NUM_PORTS-1:0] doubled;
  logic [NUM_PORTS-1:0]   rotated;
  logic [IDX_W-1:0]       offset;
  logic [IDX_W:0]         sum;

  always_comb begin
    eligible = request & mask;
    doubled  = {eligible, eligible} >> pointer;
    rotated  = doubled[NUM_PORTS-1:0];
    found    = 1'b0;
    offset   = '0;
    // Scan downward so the lowest set offset wins.
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        found  = 1'b1;
        offset = IDX_W'(i);
      end
    end
    sum = {1'b0, pointer} + {1'b0, offset};
    if (sum >= (IDX_W + 1)'(NUM_PORTS)) begin
      sum = sum - (IDX_W + 1)'(NUM_PORTS);
    end
    index  = sum[IDX_W-1:0];
    onehot = found ? (NUM_PORTS'(1) << index) : '0;
  end

endmodule

// File: rtl/arbiter_hold.sv
// Round-robin arbiter granting a shared resource for a bounded multi-cycle tenure,
// with no-bubble handover to the next requester when the owner lets go.
//
//  state    | meaning
//  ARB_IDLE | nothing granted; first request found from pointer is granted next edge
//  ARB_OWN  | one port holds grant; hold_cnt counts its tenure until release/expiry
module arbiter_hold
  import arbiter_hold_pkg::*;
#(
  parameter int NUM_PORTS = 6,
  parameter int MAX_HOLD  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_PORTS-1:0]         request,
  input  logic                         release_req,
  output logic [NUM_PORTS-1:0]         grant,
  output logic [$clog2(NUM_PORTS)-1:0] select,
  output logic                         active,
  output logic                         preempt
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int CNT_W = idx_width(MAX_HOLD + 1);

  arb_state_t           state, state_d;
  logic [CNT_W-1:0]     hold_cnt, hold_cnt_d;
  logic [IDX_W-1:0]     pointer, pointer_d;
  logic [NUM_PORTS-1:0] grant_d;
  logic [IDX_W-1:0]     select_d;
  logic                 active_d, preempt_d;

  logic                 owner_gone, expiry;
  logic [NUM_PORTS-1:0] pick_mask, pick_onehot;
  logic [IDX_W-1:0]     pick_index, pick_next;
  logic                 pick_found;

  assign owner_gone = (state == ARB_OWN) && !request[select];
  assign expiry     = (state == ARB_OWN) && (hold_cnt == CNT_W'(MAX_HOLD - 1));
  // An owner that dropped its request is excluded; otherwise it stays eligible
  // but ranks last because pointer already sits just past it.
  assign pick_mask  = owner_gone ? ~grant : '1;
  assign pick_next  = (pick_index == IDX_W'(NUM_PORTS - 1)) ? '0 : pick_index + IDX_W'(1);

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .request (request),
    .mask    (pick_mask),
    .pointer (pointer),
    .onehot  (pick_onehot),
    .index   (pick_index),
    .found   (pick_found)
  );

  always_comb begin
    state_d    = state;
    grant_d    = grant;
    select_d   = select;
    active_d   = active;
    preempt_d  = 1'b0;
    hold_cnt_d = hold_cnt;
    pointer_d  = pointer;

    case (state)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d    = ARB_OWN;
          grant_d    = pick_onehot;
          select_d   = pick_index;
          active_d   = 1'b1;
          hold_cnt_d = '0;
          pointer_d  = pick_next;
        end
      end
      ARB_OWN: begin
        if (release_req || owner_gone || expiry) begin
          preempt_d = expiry && !release_req;
          if (pick_found) begin
            grant_d    = pick_onehot;
            select_d   = pick_index;
            active_d   = 1'b1;
            hold_cnt_d = '0;
            pointer_d  = pick_next;
          end else begin
            state_d    = ARB_IDLE;
            grant_d    = '0;
            select_d   = '0;
            active_d   = 1'b0;
            hold_cnt_d = '0;
          end
        end else begin
          hold_cnt_d = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d    = ARB_IDLE;
        grant_d    = '0;
        select_d   = '0;
        active_d   = 1'b0;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      grant    <= '0;
      select   <= '0;
      active   <= 1'b0;
      preempt  <= 1'b0;
      hold_cnt <= '0;
      pointer  <= '0;
    end else begin
      state    <= state_d;
      grant    <= grant_d;
      select   <= select_d;
      active   <= active_d;
      preempt  <= preempt_d;
      hold_cnt <= hold_cnt_d;
      pointer  <= pointer_d;
    end
  end

endmodule

// File: tb/tb_arbiter_hold.sv
// Bench for arbiter_hold: a MAX_HOLD=4 and a MAX_HOLD=1 instance share stimulus and are
// compared each cycle against a tenure-level reference model, plus directed scenario checks.
module tb_arbiter_hold;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] request;
  logic       release_req;

  logic [3:0] g0, g1;
  logic [1:0] s0, s1;
  logic       a0, a1, p0, p1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state per instance: owner index (-1 = none), cycles held, next-priority port.
  int m_own[2];
  int m_cnt[2];
  int m_ptr[2];
  bit m_pre[2];

  always #5 clk = ~clk;

  arbiter_hold #(.NUM_PORTS(4), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .request(request), .release_req(release_req),
    .grant(g0), .select(s0), .active(a0), .preempt(p0)
  );

  arbiter_hold #(.NUM_PORTS(4), .MAX_HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .request(request), .release_req(release_req),
    .grant(g1), .select(s1), .active(a1), .preempt(p1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int max_hold(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_own[d] = -1;
      m_cnt[d] = 0;
      m_ptr[d] = 0;
      m_pre[d] = 1'b0;
    end
  endtask

  task automatic model_step(input int d, input logic [3:0] r, input logic rel);
    logic [3:0] elig;
    int pick;
    bit b, c;
    elig     = r;
    m_pre[d] = 1'b0;
    if (m_own[d] >= 0) begin
      b = !r[m_own[d]];
      c = (m_cnt[d] == max_hold(d) - 1);
      if (!(rel || b || c)) begin
        m_cnt[d]++;
        return;
      end
      m_pre[d] = c && !rel;
      if (b) elig[m_own[d]] = 1'b0;
    end
    pick = -1;
    for (int k = 0; k < 4; k++) begin
      if (pick < 0 && elig[(m_ptr[d] + k) % 4]) pick = (m_ptr[d] + k) % 4;
    end
    if (pick >= 0) begin
      m_own[d] = pick;
      m_cnt[d] = 0;
      m_ptr[d] = (pick + 1) % 4;
    end else begin
      m_own[d] = -1;
      m_cnt[d] = 0;
    end
  endtask

  task automatic compare_all();
    logic [3:0] eg;
    logic [1:0] es;
    for (int d = 0; d < 2; d++) begin
      eg = (m_own[d] >= 0) ? (4'b0001 << m_own[d]) : 4'b0000;
      es = (m_own[d] >= 0) ? 2'(m_own[d]) : 2'd0;
      if (d == 0) begin
        chk("grant_h4", 32'(g0), 32'(eg));
        chk("select_h4", 32'(s0), 32'(es));
        chk("active_h4", 32'(a0), 32'(m_own[0] >= 0));
        chk("preempt_h4", 32'(p0), 32'(m_pre[0]));
      end else begin
        chk("grant_h1", 32'(g1), 32'(eg));
        chk("select_h1", 32'(s1), 32'(es));
        chk("active_h1", 32'(a1), 32'(m_own[1] >= 0));
        chk("preempt_h1", 32'(p1), 32'(m_pre[1]));
      end
    end
  endtask

  // Drive inputs (called at a falling edge), take one rising edge, check at the next falling edge.
  task automatic cyc(input logic [3:0] r, input logic rel);
    request     = r;
    release_req = rel;
    @(posedge clk);
    model_step(0, r, rel);
    model_step(1, r, rel);
    @(negedge clk);
    compare_all();
  endtask

  // Assert reset partway through a low phase and confirm outputs drop without a clock edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("async_rst_active", 32'(a0 | a1), 32'd0);
    @(negedge clk);
    request     = 4'b0000;
    release_req = 1'b0;
    rst_n       = 1'b1;
  endtask

  int n_pre;
  logic [3:0] rnd_req;

  initial begin
    rst_n       = 1'b0;
    request     = 4'b0000;
    release_req = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Scenario 1: first grant latency, then reset mid-tenure.
    cyc(4'b1010, 1'b0);
    chk("s1_grant", 32'(g0), 32'h2);
    chk("s1_select", 32'(s0), 32'd1);
    cyc(4'b1010, 1'b0);
    do_reset();

    // Scenario 2: all request, owner releases on the second cycle of each tenure.
    for (int i = 0; i < 9; i++) begin
      cyc(4'b1111, (m_own[0] >= 0) && (m_cnt[0] == 1));
      chk("s2_no_bubble", 32'(a0), 32'd1);
    end
    chk("s2_wrap_grant", 32'(g0), 32'h1);
    do_reset();

    // Scenario 3: expiry hands port 0's tenure to port 1 with a preempt pulse.
    for (int i = 0; i < 4; i++) cyc(4'b0011, 1'b0);
    chk("s3_hold_port0", 32'(g0), 32'h1);
    cyc(4'b0011, 1'b0);
    chk("s3_grant", 32'(g0), 32'h2);
    chk("s3_preempt", 32'(p0), 32'd1);
    do_reset();

    // Scenario 4: sole owner drops its request and the arbiter goes idle.
    cyc(4'b0100, 1'b0);
    cyc(4'b0100, 1'b0);
    cyc(4'b0000, 1'b0);
    chk("s4_grant", 32'(g0), 32'h0);
    chk("s4_active", 32'(a0), 32'd0);

    // Scenario 5: lone requester is regranted on each expiry.
    n_pre = 0;
    for (int i = 0; i < 13; i++) begin
      cyc(4'b0100, 1'b0);
      chk("s5_grant_const", 32'(g0), 32'h4);
      n_pre += int'(p0);
    end
    chk("s5_preempt_count", 32'(n_pre), 32'd3);
    do_reset();

    // Scenario 6: release coinciding with expiry suppresses preempt.
    for (int i = 0; i < 4; i++) cyc(4'b0011, 1'b0);
    cyc(4'b0011, 1'b1);
    chk("s6_grant", 32'(g0), 32'h2);
    chk("s6_preempt", 32'(p0), 32'd0);
    do_reset();
    for (int i = 0; i < 6; i++) cyc(4'b1111, 1'b0);
    chk("s6_h1_rotate", 32'(g1), 32'h2);

    // Randomised traffic with sticky requests so tenures reach expiry.
    rnd_req = 4'b0000;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(9) < 3) rnd_req = 4'($urandom_range(15));
      if ($urandom_range(199) == 0) do_reset();
      else cyc(rnd_req, $urandom_range(3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
